// File: rtl/alu_rotator_unit.sv
// WIDTH-bit add/sub/rotate unit with C/V/Z/N flags, valid/ready accept and a one-cycle result strobe.
// Optional build macro SATURATE_EN: ADD/SUB clamp to signed limits on overflow.
module alu_rotator_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [2:0]       Control,
    input  logic [WIDTH-1:0] Input_1,
    input  logic [WIDTH-1:0] Input_2,
    output logic [WIDTH-1:0] Output,
    output logic [3:0]       Flags,
    output logic             Out_Valid
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned MSB   = WIDTH - 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ROL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_ROL1 = 3'b101;
    localparam logic [2:0] OP_ROR1 = 3'b110;

`ifdef SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [3:0]       flags_nxt;
    logic             out_valid_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic             dir, dir_nxt;

    logic [CNT_W-1:0] amt;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] arith_res;
    logic             arith_c, arith_v;
    logic [WIDTH-1:0] work_rot;
    logic             work_wrap;

    function automatic logic [3:0] flags_of(input logic [WIDTH-1:0] r,
                                            input logic cf, input logic vf);
        return {cf, vf, (r == '0), r[MSB]};
    endfunction

    assign In_Ready = (state == IDLE);
    assign amt      = Input_2[CNT_W-1:0];
    assign sum      = {1'b0, Input_1} + {1'b0, Input_2};
    assign diff     = {1'b0, Input_1} - {1'b0, Input_2};

    // dir: 0 rotates left, 1 rotates right (matches Control[0] of ROL/ROR)
    assign work_rot  = dir ? {work[0], work[MSB:1]} : {work[MSB-1:0], work[MSB]};
    assign work_wrap = dir ? work[0] : work[MSB];

    // Shared add/sub datapath; carry and overflow always come from the raw result
    always_comb begin
        arith_res = '0;
        arith_c   = 1'b0;
        arith_v   = 1'b0;
        if (Control == OP_SUB) begin
            arith_res = diff[MSB:0];
            arith_c   = diff[WIDTH];
            arith_v   = (Input_1[MSB] != Input_2[MSB]) && (diff[MSB] != Input_1[MSB]);
        end else begin
            arith_res = sum[MSB:0];
            arith_c   = sum[WIDTH];
            arith_v   = (Input_1[MSB] == Input_2[MSB]) && (sum[MSB] != Input_1[MSB]);
        end
`ifdef SATURATE_EN
        if (arith_v) begin
            arith_res = Input_1[MSB] ? SAT_NEG : SAT_POS;
        end
`endif
    end

    always_comb begin
        state_nxt     = state;
        out_nxt       = Output;
        flags_nxt     = Flags;
        out_valid_nxt = 1'b0;
        cnt_nxt       = cnt;
        work_nxt      = work;
        dir_nxt       = dir;

        case (state)
            IDLE: begin
                if (In_Valid) begin
                    out_valid_nxt = 1'b1;
                    case (Control)
                        OP_ADD, OP_SUB: begin
                            out_nxt   = arith_res;
                            flags_nxt = flags_of(arith_res, arith_c, arith_v);
                        end
                        OP_ROL, OP_ROR: begin
                            if (amt == '0) begin
                                out_nxt   = Input_1;
                                flags_nxt = flags_of(Input_1, 1'b0, 1'b0);
                            end else begin
                                out_valid_nxt = 1'b0;
                                work_nxt      = Input_1;
                                cnt_nxt       = amt;
                                dir_nxt       = Control[0];
                                state_nxt     = BUSY;
                            end
                        end
                        OP_LOAD: begin
                            out_nxt   = Input_1;
                            flags_nxt = flags_of(Input_1, 1'b0, 1'b0);
                        end
                        OP_ROL1: begin
                            out_nxt   = {Output[MSB-1:0], Output[MSB]};
                            flags_nxt = flags_of({Output[MSB-1:0], Output[MSB]}, Output[MSB], 1'b0);
                        end
                        OP_ROR1: begin
                            out_nxt   = {Output[0], Output[MSB:1]};
                            flags_nxt = flags_of({Output[0], Output[MSB:1]}, Output[0], 1'b0);
                        end
                        default: begin
                            out_nxt   = '0;
                            flags_nxt = '0;
                        end
                    endcase
                end
            end
            BUSY: begin
                work_nxt = work_rot;
                cnt_nxt  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    out_nxt       = work_rot;
                    flags_nxt     = flags_of(work_rot, work_wrap, 1'b0);
                    out_valid_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            Output    <= '0;
            Flags     <= '0;
            Out_Valid <= 1'b0;
            cnt       <= '0;
            work      <= '0;
            dir       <= 1'b0;
        end else begin
            state     <= state_nxt;
            Output    <= out_nxt;
            Flags     <= flags_nxt;
            Out_Valid <= out_valid_nxt;
            cnt       <= cnt_nxt;
            work      <= work_nxt;
            dir       <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_alu_rotator_unit.sv
// Directed bench for alu_rotator_unit (WIDTH=8): expected results are queued at issue and checked on Out_Valid.
module tb_alu_rotator_unit;

    logic       CLK;
    logic       RST_N;
    logic       In_Valid;
    logic       In_Ready;
    logic [2:0] Control;
    logic [7:0] Input_1;
    logic [7:0] Input_2;
    logic [7:0] Output;
    logic [3:0] Flags;
    logic       Out_Valid;

    alu_rotator_unit #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Control   (Control),
        .Input_1   (Input_1),
        .Input_2   (Input_2),
        .Output    (Output),
        .Flags     (Flags),
        .Out_Valid (Out_Valid)
    );

    typedef struct {
        logic [7:0] out;
        logic [3:0] flags;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         errors;
    int         checks;
    int         cycle;
    int         ov_count;
    logic [7:0] model_out;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one operation at WIDTH=8
    task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] prev, output logic [7:0] r, output logic [3:0] f);
        logic [8:0] s;
        logic       c;
        logic       v;
        int         n;
        c = 1'b0;
        v = 1'b0;
        r = 8'h00;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd2, 3'd3: begin
                r = a;
                n = int'(b[2:0]);
                for (int i = 0; i < n; i++) begin
                    if (op == 3'd2) begin
                        c = r[7];
                        r = {r[6:0], r[7]};
                    end else begin
                        c = r[0];
                        r = {r[0], r[7:1]};
                    end
                end
            end
            3'd4: r = a;
            3'd5: begin
                c = prev[7];
                r = {prev[6:0], prev[7]};
            end
            3'd6: begin
                c = prev[0];
                r = {prev[0], prev[7:1]};
            end
            default: r = 8'h00;
        endcase
`ifdef SATURATE_EN
        if (v && op <= 3'd1) r = a[7] ? 8'h80 : 8'h7F;
`endif
        f = (op == 3'd7) ? 4'b0000 : {c, v, (r == 8'h00), r[7]};
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [7:0] r;
        logic [3:0] f;
        model(op, a, b, model_out, r, f);
        e.out   = r;
        e.flags = f;
        e.due   = cycle + 1;
        if ((op == 3'd2 || op == 3'd3) && b[2:0] != 3'd0) e.due = e.due + int'(b[2:0]);
        model_out = r;
        sb.push_back(e);
    endtask

    // One clock; sample 1 time unit after the edge and score any completed result
    task automatic tick();
        exp_t e;
        @(posedge CLK);
        cycle++;
        #1;
        if (Out_Valid === 1'b1) begin
            ov_count++;
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'(Out_Valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("latency_cycle", 32'(cycle), 32'(e.due));
                check("sb_output", 32'(Output), 32'(e.out));
                check("sb_flags", 32'(Flags), 32'(e.flags));
            end
        end
    endtask

    task automatic op(input logic [2:0] ctl, input logic [7:0] a, input logic [7:0] b, input bit track);
        int guard;
        guard = 0;
        while (In_Ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (In_Ready !== 1'b1) check("ready_timeout", 32'(In_Ready), 32'd1);
        if (track) push_exp(ctl, a, b);
        In_Valid = 1'b1;
        Control  = ctl;
        Input_1  = a;
        Input_2  = b;
        tick();
        In_Valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] old;
        int         ov0;
        errors    = 0;
        checks    = 0;
        cycle     = 0;
        ov_count  = 0;
        model_out = 8'h00;
        RST_N     = 1'b0;
        In_Valid  = 1'b0;
        Control   = 3'd0;
        Input_1   = 8'h00;
        Input_2   = 8'h00;

        tick();
        tick();
        check("rst_output", 32'(Output), 32'h00);
        check("rst_flags", 32'(Flags), 32'h0);
        check("rst_out_valid", 32'(Out_Valid), 32'd0);
        check("rst_in_ready", 32'(In_Ready), 32'd1);
        RST_N = 1'b1;
        tick();

        // ADD with signed overflow
        op(3'd0, 8'h7F, 8'h01, 1'b1);
        drain();
`ifdef SATURATE_EN
        check("add_ovf_output", 32'(Output), 32'h7F);
        check("add_ovf_flags", 32'(Flags), 32'h4);
`else
        check("add_ovf_output", 32'(Output), 32'h80);
        check("add_ovf_flags", 32'(Flags), 32'h5);
`endif
        op(3'd0, 8'hFF, 8'h01, 1'b1);
        drain();

        // SUB borrow and zero
        op(3'd1, 8'h00, 8'h01, 1'b1);
        drain();
        check("sub_borrow_output", 32'(Output), 32'hFF);
        check("sub_borrow_flags", 32'(Flags), 32'h9);
        op(3'd1, 8'h05, 8'h05, 1'b1);
        drain();
        check("sub_zero_output", 32'(Output), 32'h00);
        check("sub_zero_flags", 32'(Flags), 32'h2);
        op(3'd1, 8'h80, 8'h01, 1'b1);
        drain();

        // Multi-cycle ROL: busy for amt cycles with Output held
        op(3'd4, 8'h3C, 8'h00, 1'b1);
        drain();
        old = Output;
        ov0 = ov_count;
        op(3'd2, 8'h81, 8'h03, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("rol_busy_ready", 32'(In_Ready), 32'd0);
            check("rol_hold_output", 32'(Output), 32'(old));
            if (i < 2) tick();
        end
        drain();
        tick();
        check("rol_pulse_count", 32'(ov_count - ov0), 32'd1);
        check("rol_output", 32'(Output), 32'h0C);
        check("rol_flags", 32'(Flags), 32'h0);

        op(3'd3, 8'h01, 8'h01, 1'b1);
        drain();
        check("ror1amt_output", 32'(Output), 32'h80);
        check("ror1amt_flags", 32'(Flags), 32'h9);

        // Rotate by zero completes in one cycle
        op(3'd3, 8'h5A, 8'h00, 1'b1);
        check("ror0_latency", 32'(Out_Valid), 32'd1);
        check("ror0_output", 32'(Output), 32'h5A);
        check("ror0_flags", 32'(Flags), 32'h0);

        // Back-to-back LOAD, ROL1, CLR with In_Valid held
        ov0 = ov_count;
        In_Valid = 1'b1;
        push_exp(3'd4, 8'h81, 8'h00);
        Control = 3'd4;
        Input_1 = 8'h81;
        Input_2 = 8'h00;
        tick();
        push_exp(3'd5, 8'h00, 8'h00);
        Control = 3'd5;
        tick();
        check("b2b_rol1_output", 32'(Output), 32'h03);
        check("b2b_rol1_flags", 32'(Flags), 32'h8);
        push_exp(3'd7, 8'h00, 8'h00);
        Control = 3'd7;
        tick();
        In_Valid = 1'b0;
        check("b2b_pulse_count", 32'(ov_count - ov0), 32'd3);
        check("b2b_clr_output", 32'(Output), 32'h00);
        check("b2b_clr_flags", 32'(Flags), 32'h0);
        tick();

        // Mixed operations against the model
        for (int k = 0; k < 10; k++) begin
            op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1);
            drain();
        end
        tick();

        // Reset in the middle of a rotate
        op(3'd4, 8'hA5, 8'h00, 1'b1);
        drain();
        op(3'd2, 8'h3C, 8'h05, 1'b0);
        tick();
        tick();
        RST_N = 1'b0;
        #1;
        check("midrst_output", 32'(Output), 32'h00);
        check("midrst_flags", 32'(Flags), 32'h0);
        check("midrst_out_valid", 32'(Out_Valid), 32'd0);
        check("midrst_in_ready", 32'(In_Ready), 32'd1);
        sb.delete();
        model_out = 8'h00;
        tick();
        tick();
        RST_N = 1'b1;
        op(3'd0, 8'h02, 8'h03, 1'b1);
        drain();
        check("post_rst_output", 32'(Output), 32'h05);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
